array_mult_pipe: RTL and testbench
==================================

Name: array_mult_pipe

Overview:
Parametrised, pipelined unsigned array multiplier. Next generation of the team's combinational 4x4 array multiplier.
Same AND-matrix / full-adder-row structure, generalised to WIDTH-bit operands. Pipeline registers are inserted every ROWS_PER_STAGE adder rows.
Valid/ready handshake with backpressure. Sits between operand source and result sink in the arithmetic datapath.

Parameters:
WIDTH, 4, operand width in bits (2..16); product width is 2*WIDTH.
ROWS_PER_STAGE, 1, partial-product rows reduced per pipeline stage (1..WIDTH).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
out_valid  out  1  product valid
out_ready  in  1  sink accepts product
out_p  out  2*WIDTH  product a*b
busy  out  1  any pipeline stage holds a valid item

Behaviour:
- STAGES = ceil(WIDTH/ROWS_PER_STAGE).
- Each stage register holds: valid bit; running partial sum; carry vector; remaining operand bits needed by later rows.
- Row k adds (in_a & {WIDTH{in_b[k]}}) shifted by k. Final carry-propagate add is done in the last stage.
- Accept: in_valid && in_ready at edge t. Product is on out_p with out_valid=1 from edge t+STAGES, provided no stall occurs.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - On stall, every stage register holds its value, including bubbles. No bubble collapsing.
  - out_p and out_valid stay stable while stalled.
- No stall: every stage advances each cycle. Stage 0 loads in_valid && in_ready; bubbles enter as valid=0.
- Throughput: one product per cycle when out_ready=1 continuously.
- Arithmetic:
  - Unsigned, exact, no truncation.
  - out_p = in_a*in_b, 2*WIDTH bits; max (2^WIDTH-1)^2 fits.
- out_p is don't-care when out_valid=0. Data registers are not reset. The bench must not check out_p while out_valid=0.
- busy = OR of all stage valid bits.
- Reset:
  - rst_n low clears all stage valid bits immediately.
  - out_valid=0, busy=0, in_ready=1 while in reset.
  - Items in flight at reset are discarded, never emitted.
  - First accept is possible on the first rising edge after rst_n deasserts.
- Simultaneous events: when stall clears (out_ready=1) in the same cycle in_valid=1, the input is accepted and the output is consumed on the same edge.
- ROWS_PER_STAGE=WIDTH gives STAGES=1: a single registered stage, latency 1.

Optional Feature:
Macro ARRAY_MULT_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), sampled with operands at accept and carried down the pipeline per item.
  - in_signed=1: operands are two's complement; product computed by Baugh-Wooley (inverted MSB-row/column partial products plus correction constants). out_p is the 2*WIDTH-bit two's complement product.
  - in_signed=0: unsigned, identical to the base behaviour.
  - Latency unchanged.
- Undefined: port absent, unsigned only. Gate count and timing identical to the base design.

Test Plan:
1. WIDTH=4, ROWS_PER_STAGE=1, out_ready=1; accept a=15,b=15 at edge t -> out_valid at edge t+4, out_p=225; a=0,b=13 -> 0.
2. WIDTH=8, ROWS_PER_STAGE=2; back-to-back 255*255, 1*1, 128*2, one per cycle -> 65025, 1, 256 on consecutive cycles from latency 4; busy=1 throughout, then 0.
3. Backpressure: WIDTH=4; issue 3*5, 6*7, 9*9 with out_ready=0 after first result appears -> in_ready=0; out_p held at 15 for 5 cycles; raise out_ready -> 15, 42, 81 in order; no loss or duplication.
4. Reset mid-operation: two items in flight, pulse rst_n low between edges -> out_valid and busy drop immediately; neither item is ever emitted; next accept 2*3 -> 6 at normal latency.
5. Random: 1000 random operand pairs, random in_valid/out_ready at 50% each, WIDTH=8, ROWS_PER_STAGE=3 -> scoreboard matches a*b in order.
6. ARRAY_MULT_SIGNED_EN, WIDTH=4: (-8)*(-8) -> 64 (8'h40); (-8)*7 -> -56 (8'hC8); signed=0 with 8*7 -> 56.

Source files
------------

// File: rtl/array_mult_pipe.sv
// array_mult_pipe: pipelined WIDTH x WIDTH array multiplier, valid/ready.
// Macro ARRAY_MULT_SIGNED_EN adds in_signed (Baugh-Wooley signed mode).
module array_mult_pipe #(
   parameter int WIDTH          = 4,
   parameter int ROWS_PER_STAGE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
`ifdef ARRAY_MULT_SIGNED_EN
   input  logic               in_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int P      = 2 * WIDTH;
   localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
   // rank 0 captures operands, ranks 1..STAGES reduce rows
   localparam int NR     = STAGES + 1;

   // Baugh-Wooley correction constants: +2^W and +2^(2W-1)
   localparam logic [P-1:0] BW_K = (P'(1) << WIDTH) | (P'(1) << (P - 1));
   localparam logic [WIDTH-1:0] MSB_M = {1'b1, {(WIDTH-1){1'b0}}};

   logic [NR-1:0]    vld_q, vld_d;
   logic [P-1:0]     sum_q [NR];
   logic [P-1:0]     sum_d [NR];
   logic [P-1:0]     cry_q [NR];
   logic [P-1:0]     cry_d [NR];
   logic [WIDTH-1:0] a_q   [NR];
   logic [WIDTH-1:0] a_d   [NR];
   logic [WIDTH-1:0] b_q   [NR];
   logic [WIDTH-1:0] b_d   [NR];
`ifdef ARRAY_MULT_SIGNED_EN
   logic             sgn_q [NR];
   logic             sgn_d [NR];
`endif
   logic             stall;

   // one partial-product row k, with MSB row/column inverted in signed mode
   function automatic logic [P-1:0] pp_row(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input int               k,
      input logic             sg
   );
      logic [WIDTH-1:0] bs;
      logic [WIDTH-1:0] r;
      bs = b >> k;
      r  = a & {WIDTH{bs[0]}};
      if (sg) begin
         if (k == WIDTH - 1) r = r ^ ~MSB_M;
         else                r = r ^ MSB_M;
      end
      return {{WIDTH{1'b0}}, r} << k;
   endfunction

   assign out_valid = vld_q[NR-1];
   assign out_p     = sum_q[NR-1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign busy      = |vld_q;

   // next-state of every rank: operand capture, carry-save rows, final add
   always_comb begin
      logic [P-1:0] s_t;
      logic [P-1:0] c_t;
      logic [P-1:0] pp;
      logic [P-1:0] ns;
      logic         sg;
      int           k;
      s_t = '0;
      c_t = '0;
      pp  = '0;
      ns  = '0;
      sg  = 1'b0;
      k   = 0;
      vld_d    = {vld_q[NR-2:0], in_valid};
      a_d[0]   = in_a;
      b_d[0]   = in_b;
      cry_d[0] = '0;
`ifdef ARRAY_MULT_SIGNED_EN
      sgn_d[0] = in_signed;
      sum_d[0] = in_signed ? BW_K : '0;
`else
      sum_d[0] = '0;
`endif
      for (int s = 1; s < NR; s++) begin
`ifdef ARRAY_MULT_SIGNED_EN
         sg       = sgn_q[s-1];
         sgn_d[s] = sgn_q[s-1];
`else
         sg = 1'b0;
`endif
         s_t = sum_q[s-1];
         c_t = cry_q[s-1];
         for (int r = 0; r < ROWS_PER_STAGE; r++) begin
            k = (s - 1) * ROWS_PER_STAGE + r;
            if (k < WIDTH) begin
               pp  = pp_row(a_q[s-1], b_q[s-1], k, sg);
               ns  = s_t ^ c_t ^ pp;
               c_t = ((s_t & c_t) | (s_t & pp) | (c_t & pp)) << 1;
               s_t = ns;
            end
         end
         a_d[s] = a_q[s-1];
         b_d[s] = b_q[s-1];
         if (s == NR - 1) begin
            sum_d[s] = s_t + c_t;
            cry_d[s] = '0;
         end else begin
            sum_d[s] = s_t;
            cry_d[s] = c_t;
         end
      end
   end

   // valid bits: cleared by reset, frozen together with data on stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (!stall) begin
         vld_q <= vld_d;
      end
   end

   // data ranks are not reset; they only move when the pipe advances
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int s = 0; s < NR; s++) begin
            sum_q[s] <= sum_d[s];
            cry_q[s] <= cry_d[s];
            a_q[s]   <= a_d[s];
            b_q[s]   <= b_d[s];
`ifdef ARRAY_MULT_SIGNED_EN
            sgn_q[s] <= sgn_d[s];
`endif
         end
      end
   end

endmodule

// File: tb/tb_array_mult_pipe.sv
// tb_array_mult_pipe: scoreboard bench for array_mult_pipe.
// WIDTH=8, ROWS_PER_STAGE=3 (three reduction stages, last one partial).
module tb_array_mult_pipe;

   localparam int W   = 8;
   localparam int RPS = 3;
   localparam int ST  = (W + RPS - 1) / RPS;
   localparam int P   = 2 * W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic         sgn = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [P-1:0] out_p;

   int           total = 0;
   int           bad = 0;
   logic [P-1:0] exp_q [$];

   array_mult_pipe #(.WIDTH(W), .ROWS_PER_STAGE(RPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef ARRAY_MULT_SIGNED_EN
      .in_signed (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [P-1:0] model(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         s
   );
      logic signed [P-1:0] r;
      if (s) r = $signed(a) * $signed(b);
      else   r = a * b;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // scoreboard monitor: outputs checked first, then new accepts queued
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got %0d want none", out_p);
            end else begin
               chk("out_p", {48'd0, out_p}, {48'd0, exp_q[0]});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, sgn));
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
      logic rdy;
      int   n;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      sgn = s;
      n = 0;
      do begin
         #3;
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: got in_ready=0 want 1");
      end
      in_valid = 1'b0;
   endtask

   task automatic lat_check(input logic [P-1:0] p);
      for (int i = 0; i < ST; i++) begin
         chk("lat_early", {63'd0, out_valid}, 64'd0);
         @(posedge clk);
         #1;
      end
      chk("lat_valid", {63'd0, out_valid}, 64'd1);
      chk("lat_p", {48'd0, out_p}, {48'd0, p});
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wait_valid", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_q", 64'(exp_q.size()), 64'd0);
      chk("drain_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rdy;
      int   sent;
      int   cyc;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      rst_n = 1'b1;

      // first edge after release accepts; fixed latency
      issue(8'd15, 8'd15, 1'b0);
      chk("busy_on", {63'd0, busy}, 64'd1);
      lat_check(16'd225);
      issue(8'd0, 8'd13, 1'b0);
      drain();

      // back-to-back, one result per cycle
      issue(8'd255, 8'd255, 1'b0);
      issue(8'd1, 8'd1, 1'b0);
      issue(8'd128, 8'd2, 1'b0);
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         chk("b2b_valid", {63'd0, out_valid}, 64'd1);
         chk("b2b_busy", {63'd0, busy}, 64'd1);
         @(posedge clk);
         #1;
      end
      chk("b2b_end", {63'd0, out_valid}, 64'd0);
      drain();

      // backpressure holds the head result
      issue(8'd3, 8'd5, 1'b0);
      issue(8'd6, 8'd7, 1'b0);
      issue(8'd9, 8'd9, 1'b0);
      wait_valid();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold", {48'd0, out_p}, 64'd15);
      end
      drain();

      // reset with items in flight, one already at the output
      issue(8'd11, 8'd13, 1'b0);
      issue(8'd7, 8'd7, 1'b0);
      issue(8'd5, 8'd5, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      exp_q.delete();
      rst_n = 1'b1;
      issue(8'd2, 8'd3, 1'b0);
      lat_check(16'd6);
      drain();

      // random traffic with random backpressure
      sent = 0;
      cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         out_ready = 1'($urandom);
         if (!in_valid && 1'($urandom)) begin
            in_valid = 1'b1;
            in_a = W'($urandom);
            in_b = W'($urandom);
`ifdef ARRAY_MULT_SIGNED_EN
            sgn = 1'($urandom);
`endif
         end
         #3;
         rdy = in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (in_valid && rdy) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("rand_sent", 64'(sent), 64'd1000);
      drain();

`ifdef ARRAY_MULT_SIGNED_EN
      issue(8'hF8, 8'hF8, 1'b1);
      lat_check(16'd64);
      issue(8'hF8, 8'd7, 1'b1);
      lat_check(16'hFFC8);
      issue(8'd8, 8'd7, 1'b0);
      lat_check(16'd56);
      issue(8'h80, 8'h80, 1'b1);
      lat_check(16'd16384);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
